// File: rtl/dff_mux_arbiter.sv
// Registered 4:1 data selector driven by a round-robin arbiter that lets the
// current owner keep the grant for up to BURST consecutive beats.
module dff_mux_arbiter #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  output logic [3:0]    gnt,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_src,
  input  logic          out_ready
);

  localparam logic [3:0] BLIM = 4'(BURST);

  logic [1:0]    owner;
  logic [3:0]    bcnt;
  logic          space;
  logic          accept;
  logic          cont;
  logic [1:0]    win;
  logic [DW-1:0] win_data;

  assign space  = ~out_valid | out_ready;
  assign accept = space & (|req);
  assign cont   = req[owner] && (bcnt != 4'd0) && (bcnt < BLIM);

  // Scan from farthest to nearest so the nearest requester after owner wins.
  always_comb begin
    win = owner;
    if (!cont) begin
      for (int k = 4; k >= 1; k--) begin
        if (req[owner + 2'(k)]) win = owner + 2'(k);
      end
    end
  end

  always_comb begin
    gnt = 4'b0000;
    if (accept && !rst) gnt[win] = 1'b1;
  end

  always_comb begin
    case (win)
      2'd0:    win_data = din0;
      2'd1:    win_data = din1;
      2'd2:    win_data = din2;
      default: win_data = din3;
    endcase
  end

  // Owner resets to 3 so the first scan after reset starts at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      owner     <= 2'd3;
      bcnt      <= 4'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_src   <= win;
      owner     <= win;
      bcnt      <= cont ? bcnt + 4'd1 : 4'd1;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (!req[owner]) bcnt <= 4'd0;
    end
  end

endmodule

// File: tb/tb_dff_mux_arbiter.sv
// Self-checking bench for dff_mux_arbiter: a cycle model predicts grants and
// a scoreboard queue holds beats until they drain downstream.
module tb_dff_mux_arbiter;

  localparam int DW    = 8;
  localparam int BURST = 4;

  typedef struct {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] din [4];
  logic [3:0]    gnt;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]    m_owner;
  int            m_bcnt;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    m_src;
  beat_t         sb [$];

  logic [3:0] burst_seq [9];

  dff_mux_arbiter #(.DW(DW), .BURST(BURST)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din0     (din[0]),
    .din1     (din[1]),
    .din2     (din[2]),
    .din3     (din[3]),
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Rotated-priority view of the request vector relative to the owner.
  function automatic logic [1:0] modelWinner(input logic [3:0] r, input logic [1:0] own, input int cnt);
    logic [3:0] rot;
    if (r[own] && cnt > 0 && cnt < BURST) return own;
    for (int j = 0; j < 4; j++) rot[j] = r[(int'(own) + 1 + j) % 4];
    for (int j = 0; j < 4; j++) if (rot[j]) return 2'((int'(own) + 1 + j) % 4);
    return own;
  endfunction

  task automatic applyStimulus();
    logic [1:0] w;
    logic       acc;
    logic [3:0] exp_gnt;
    beat_t      b;
    #1;
    acc = !rst && (!m_valid || out_ready) && (req != 4'b0000);
    w = modelWinner(req, m_owner, m_bcnt);
    exp_gnt = acc ? (4'b0001 << w) : 4'b0000;
    checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("out_data", 32'(out_data), 32'(m_data));
    checkOutput("out_src", 32'(out_src), 32'(m_src));
    if (!rst && m_valid === 1'b1 && out_ready) begin
      checkOutput("sb_has_beat", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        b = sb.pop_front();
        checkOutput("drain_data", 32'(out_data), 32'(b.data));
        checkOutput("drain_src", 32'(out_src), 32'(b.src));
      end
    end
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 2'd0;
      m_owner = 2'd3;
      m_bcnt  = 0;
      sb.delete();
    end else if (acc) begin
      m_bcnt  = (w == m_owner && m_bcnt > 0 && m_bcnt < BURST) ? m_bcnt + 1 : 1;
      m_owner = w;
      m_valid = 1'b1;
      m_data  = din[w];
      m_src   = w;
      b.src   = w;
      b.data  = din[w];
      sb.push_back(b);
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (!req[m_owner]) m_bcnt = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    burst_seq = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1};
    m_owner = 2'bxx;
    m_bcnt  = 0;
    m_valid = 1'bx;
    m_data  = 'x;
    m_src   = 2'bxx;
    rst = 1'b1;
    req = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 8'(8'h10 * i + 1);
    @(negedge clk);

    // Reset with all requesting, then first grant goes to requester 0.
    applyStimulus();
    applyStimulus();
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    #1 checkOutput("release_gnt", 32'(gnt), 32'h1);
    applyStimulus();

    // Burst hold between requesters 0 and 1.
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    req = 4'b0011;
    din[0] = 8'hA0;
    din[1] = 8'hB1;
    for (int i = 0; i < 9; i++) begin
      #1 checkOutput("burst_seq", 32'(gnt), 32'(burst_seq[i]));
      applyStimulus();
    end

    // Owner 1 at bcnt 2 drops its request; requester 3 takes over.
    req = 4'b0010;
    applyStimulus();
    applyStimulus();
    req = 4'b1000;
    din[3] = 8'h3D;
    #1 checkOutput("owner_drop_gnt", 32'(gnt), 32'h8);
    applyStimulus();
    req = 4'b0000;
    applyStimulus();

    // Stall three cycles, then release.
    req = 4'b0100;
    din[2] = 8'h42;
    applyStimulus();
    out_ready = 1'b0;
    din[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("stall_gnt", 32'(gnt), 32'h0);
      applyStimulus();
    end
    checkOutput("stall_data", 32'(out_data), 32'h42);
    out_ready = 1'b1;
    #1 checkOutput("unstall_gnt", 32'(gnt), 32'h4);
    applyStimulus();
    req = 4'b0000;
    checkOutput("unstall_data", 32'(out_data), 32'h43);
    applyStimulus();
    applyStimulus();

    // Single beat then idle drain.
    req = 4'b0100;
    din[2] = 8'h5C;
    applyStimulus();
    req = 4'b0000;
    checkOutput("idle_valid", 32'(out_valid), 32'd1);
    checkOutput("idle_data", 32'(out_data), 32'h5C);
    checkOutput("idle_src", 32'(out_src), 32'd2);
    applyStimulus();
    checkOutput("idle_valid_low", 32'(out_valid), 32'd0);
    applyStimulus();

    // Reset in the middle of a burst.
    req = 4'b0001;
    for (int i = 0; i < 3; i++) applyStimulus();
    rst = 1'b1;
    req = 4'b1111;
    applyStimulus();
    rst = 1'b0;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    #1 checkOutput("midrst_gnt", 32'(gnt), 32'h1);
    applyStimulus();

    // Random traffic with occasional reset.
    for (int i = 0; i < 80; i++) begin
      req = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 24) == 0);
      for (int j = 0; j < 4; j++) din[j] = 8'($urandom);
      applyStimulus();
    end

    rst = 1'b0;
    req = 4'b0000;
    out_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("sb_final_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_mux_arbiter.md
DFF_MUX_ARBITER -- requirements
Module: dff_mux_arbiter

Interface
REQ-001 Parameter DW, default 8, is the data width of each requester and of the output.
REQ-002 Parameter BURST, default 4, is the maximum consecutive beats granted to one requester while others wait; legal range 1..15.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req  input  4  per-requester request; bit i means din_i is valid.
REQ-006 din0, din1, din2, din3  input  DW each  requester data words.
REQ-007 gnt  output  4  one-hot combinational grant; bit i means din_i is captured at this edge.
REQ-008 out_valid  output  1  registered; out_data holds an untaken beat.
REQ-009 out_data  output  DW  registered selected data word.
REQ-010 out_src  output  2  registered index of the requester that supplied out_data.
REQ-011 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.

Function
REQ-012 The block SHALL be a registered 4:1 data selector whose select is produced by a round-robin arbiter with burst hold.
REQ-013 The block SHALL compute space = ~out_valid | out_ready, and accept = space & (|req).
REQ-014 gnt SHALL be zero when accept is 0 or rst is 1, and otherwise one-hot at the winner index.
REQ-015 Internal state SHALL be owner (2 bits, last granted index) and bcnt (4 bits, beats granted in the current burst).
REQ-016 Winner, case continue: if req[owner]=1 and 0<bcnt<BURST, the winner SHALL be owner.
REQ-017 Winner, otherwise: the winner SHALL be the first requesting index scanning owner+1, owner+2, owner+3, owner, modulo 4.
REQ-018 On accept, out_data SHALL load din of the winner, out_src SHALL load the winner, and out_valid SHALL load 1.
REQ-019 On accept, owner SHALL load the winner.
REQ-020 On accept, bcnt SHALL load bcnt+1 when the winner equals owner and 0<bcnt<BURST, otherwise 1.
REQ-021 Without accept, if out_valid & out_ready, out_valid SHALL clear to 0 while out_data and out_src hold.
REQ-022 Without accept and without drain, out_valid, out_data and out_src SHALL hold.
REQ-023 bcnt SHALL clear to 0 in any cycle without accept in which req[owner]=0.
REQ-024 Otherwise bcnt SHALL hold during stalls, with out_valid=1 and out_ready=0.
REQ-025 Latency SHALL be one cycle: data granted at edge N appears on out_data after edge N.
REQ-026 Back-to-back beats SHALL sustain one beat per cycle while out_ready=1 and req is non-zero.
REQ-027 Simultaneous drain and accept SHALL replace the output beat in the same cycle, with out_valid staying 1.
REQ-028 Requesters SHALL hold req and din stable until their gnt bit is seen; the block does not buffer ungranted data.
REQ-029 When BURST=1, the arbiter SHALL behave as pure round-robin.

Reset
REQ-030 While rst=1, out_valid SHALL be 0, out_data 0, out_src 0, owner 3 and bcnt 0.
REQ-031 While rst=1, gnt SHALL be 0.
REQ-032 Reset asserted mid-burst or mid-stall SHALL discard the pending beat and burst state at that edge.
REQ-033 After reset, requester 0 SHALL hold highest priority.

Verification
REQ-034 Scenario "reset": rst high 2 cycles with req=4'b1111 -> gnt=0, out_valid=0, out_data=0, out_src=0; first cycle after release -> gnt=4'b0001.
REQ-035 Scenario "burst hold": BURST=4, req=4'b0011 constant, out_ready=1, din0=8'hA0, din1=8'hB1 -> gnt sequence 1,1,1,1,2,2,2,2,1 (hex); out_src lags gnt by one cycle.
REQ-036 Scenario "stall": out_valid=1, out_ready=0 for 3 cycles with req=4'b0100 -> gnt=0 and out_data stable. Then raise out_ready -> gnt=4'b0100 in that cycle, and the new beat appears the next cycle.
REQ-037 Scenario "owner drops": owner=1 with bcnt=2, req changes from 4'b0010 to 4'b1000 -> next grant 4'b1000 with bcnt=1, and no beat lost.
REQ-038 Scenario "drain idle": single beat from din2=8'h5C with out_ready=1, then req=0 -> out_valid high exactly 1 cycle, out_data=8'h5C, out_src=2.
REQ-039 Scenario "reset mid-operation": rst pulses while out_valid=1 and bcnt=3 -> next cycle out_valid=0 and bcnt=0; with req=4'b1111, the next grant is 4'b0001.
